// File: rtl/pipelined_rca.sv
// Segmented ripple-carry adder/subtractor: SEG bits per stage, NSTG stages, valid/ready
// handshake with a single global advance enable so the whole pipe shifts or holds together.
module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int NSTG = WIDTH / SEG;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             adv;

  // Subtraction is A + ~B + 1, so the incoming carry is forced high.
  assign b_eff    = SUB ? ~B : B;
  assign cin_eff  = SUB | Cin;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  genvar gi;
  generate
    for (gi = 0; gi < NSTG; gi++) begin : stg
      localparam int LO  = gi * SEG;
      localparam int REM = WIDTH - LO - SEG;

      logic [SEG-1:0]    a_seg;
      logic [SEG-1:0]    b_seg;
      logic              c_in;
      logic              v_in;
      logic [SEG:0]      seg_sum;
      logic [LO+SEG-1:0] sum_d;
      logic              valid_reg;
      logic              carry_reg;
      logic [LO+SEG-1:0] sum_reg;

      if (gi == 0) begin : g_src
        assign a_seg = A[SEG-1:0];
        assign b_seg = b_eff[SEG-1:0];
        assign c_in  = cin_eff;
        assign v_in  = in_valid;
        assign sum_d = seg_sum[SEG-1:0];
      end else begin : g_src
        assign a_seg = stg[gi-1].g_rem.a_rem_reg[SEG-1:0];
        assign b_seg = stg[gi-1].g_rem.b_rem_reg[SEG-1:0];
        assign c_in  = stg[gi-1].carry_reg;
        assign v_in  = stg[gi-1].valid_reg;
        assign sum_d = {seg_sum[SEG-1:0], stg[gi-1].sum_reg};
      end

      assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

      // Data registers only load real transactions; bubbles keep the old contents.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
        end else if (adv) begin
          valid_reg <= v_in;
          if (v_in) begin
            carry_reg <= seg_sum[SEG];
            sum_reg   <= sum_d;
          end
        end
      end

      // Not-yet-consumed operand bits, kept right-aligned so the next segment is always at bit 0.
      if (REM > 0) begin : g_rem
        logic [REM-1:0] a_rem_d;
        logic [REM-1:0] b_rem_d;
        logic [REM-1:0] a_rem_reg;
        logic [REM-1:0] b_rem_reg;

        if (gi == 0) begin : g_first
          assign a_rem_d = A[WIDTH-1:SEG];
          assign b_rem_d = b_eff[WIDTH-1:SEG];
        end else begin : g_mid
          assign a_rem_d = stg[gi-1].g_rem.a_rem_reg[REM+SEG-1:SEG];
          assign b_rem_d = stg[gi-1].g_rem.b_rem_reg[REM+SEG-1:SEG];
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_rem_reg <= '0;
            b_rem_reg <= '0;
          end else if (adv && v_in) begin
            a_rem_reg <= a_rem_d;
            b_rem_reg <= b_rem_d;
          end
        end
      end

      // Signed overflow: carry into the MSB (recovered from the MSB sum bit) vs carry out.
      if (gi == NSTG - 1) begin : g_last
        logic msb_cin;
        logic ovf_reg;

        assign msb_cin = seg_sum[SEG-1] ^ a_seg[SEG-1] ^ b_seg[SEG-1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (adv && v_in) begin
            ovf_reg <= msb_cin ^ seg_sum[SEG];
          end
        end
      end
    end
  endgenerate

  assign out_valid = stg[NSTG-1].valid_reg;
  assign S         = stg[NSTG-1].sum_reg;
  assign Cout      = stg[NSTG-1].carry_reg;
  assign OVF       = stg[NSTG-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed and random checks for pipelined_rca at WIDTH=16, SEG=4 (four stages).
module tb_pipelined_rca;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        SUB;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        Cout;
  logic        OVF;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int NRAND = 10000;

  pipelined_rca #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .OVF       (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {OVF, Cout, S}
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
    logic [15:0] be;
    logic        c;
    logic [16:0] r;
    logic        ovf;
    be  = sub ? ~b : b;
    c   = sub ? 1'b1 : cin;
    r   = {1'b0, a} + {1'b0, be} + {16'd0, c};
    ovf = (a[15] == be[15]) && (r[15] != a[15]);
    return {ovf, r};
  endfunction

  // Issue one operand set from an idle pipe and report latency and the first result seen.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output int lat, output logic [15:0] s,
                         output logic cout, output logic ovf);
    A = a; B = b; Cin = cin; SUB = sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat = -1; s = 'x; cout = 1'bx; ovf = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = i; s = S; cout = Cout; ovf = OVF;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; A = 16'hAAAA; B = 16'h5555; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (S !== 16'h0000) begin n_fail++; $display("FAIL reset_S: got %h want 0000", S); end
    n_checks++; if ({Cout, OVF} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf: got %b want 00", {Cout, OVF}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_capture[%0d]: out_valid got %b want 0", i, out_valid); end
    end
    $display("reset: done, %0d failures so far", n_fail);
  endtask

  task automatic test_single_add();
    int lat; logic [15:0] s; logic c, o;
    run_one(16'h1234, 16'h1111, 1'b0, 1'b0, lat, s, c, o);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_checks++; if (s !== 16'h2345) begin n_fail++; $display("FAIL add_S: got %h want 2345", s); end
    n_checks++; if ({c, o} !== 2'b00) begin n_fail++; $display("FAIL add_cout_ovf: got %b want 00", {c, o}); end
    $display("add: 1234+1111 -> S=%h Cout=%b OVF=%b lat=%0d", s, c, o, lat);
  endtask

  task automatic test_vectors();
    // a, b, cin, sub, expected S, Cout, OVF
    logic [15:0] va [6] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h8000, 16'h0F0F};
    logic [15:0] vb [6] = '{16'h0000, 16'h0001, 16'h0007, 16'h0001, 16'h8000, 16'h00F1};
    logic        vc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] es [6] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000, 16'h0E1E};
    logic        ec [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        eo [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic [15:0] s; logic c, o;
    for (int i = 0; i < 6; i++) begin
      run_one(va[i], vb[i], vc[i], vs[i], lat, s, c, o);
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL vec[%0d]_latency: got %0d want 4", i, lat); end
      n_checks++; if (s !== es[i]) begin n_fail++; $display("FAIL vec[%0d]_S: got %h want %h", i, s, es[i]); end
      n_checks++; if (c !== ec[i]) begin n_fail++; $display("FAIL vec[%0d]_Cout: got %b want %b", i, c, ec[i]); end
      n_checks++; if (o !== eo[i]) begin n_fail++; $display("FAIL vec[%0d]_OVF: got %b want %b", i, o, eo[i]); end
      $display("vec[%0d]: A=%h B=%h Cin=%b SUB=%b -> S=%h Cout=%b OVF=%b", i, va[i], vb[i], vc[i], vs[i], s, c, o);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_s [8] = '{16'h1212, 16'h2323, 16'h3434, 16'h4545,
                               16'h5656, 16'h6767, 16'h7878, 16'h8989};
    int sent = 0, recvd = 0, stall = 0;
    logic seen = 1'b0, take, give;
    logic [15:0] held_s = '0;
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 60 && recvd < 8; cyc++) begin
      in_valid = (sent < 8);
      A = 16'h1111 * 16'(sent + 1); B = 16'h0101; Cin = 1'b0; SUB = 1'b0;
      if (out_valid === 1'b1 && !seen) begin seen = 1'b1; stall = 3; held_s = S; end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); end
        n_checks++; if (S !== held_s) begin n_fail++; $display("FAIL b2b_stall_hold: S got %h want %h", S, held_s); end
      end
      take = in_valid && in_ready;
      give = out_valid && out_ready;
      if (give) begin
        n_checks++; if (S !== exp_s[recvd]) begin n_fail++; $display("FAIL b2b_result[%0d]: S got %h want %h", recvd, S, exp_s[recvd]); end
        n_checks++; if ({Cout, OVF} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags[%0d]: got %b want 00", recvd, {Cout, OVF}); end
        $display("b2b: result %0d S=%h", recvd, S);
        recvd++;
      end
      if (take) sent++;
      @(posedge clk); #1;
      if (stall > 0) stall--;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (recvd != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", recvd); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    int lat; logic [15:0] s; logic c, o;
    out_ready = 1'b1; SUB = 1'b0; Cin = 1'b0; B = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      A = 16'h1111 * 16'(i + 1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid: got %b want 0", out_valid); end
    n_checks++; if ({S, Cout, OVF} !== 18'd0) begin n_fail++; $display("FAIL midrst_async_outputs: got %h want 0", {S, Cout, OVF}); end
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale[%0d]: out_valid got %b want 0", i, out_valid); end
    end
    run_one(16'h0F0F, 16'h0101, 1'b1, 1'b0, lat, s, c, o);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    n_checks++; if ({s, c, o} !== {16'h1011, 2'b00}) begin n_fail++; $display("FAIL midrst_result: got %h/%b/%b want 1011/0/0", s, c, o); end
    $display("midrst: post-reset S=%h lat=%0d", s, lat);
  endtask

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] e, held;
    int sent = 0, got = 0, nprint = 0;
    logic stuck = 1'b0, hold_v = 1'b0, take, give;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    held = '0;
    for (int cyc = 0; cyc < 60000 && got < NRAND; cyc++) begin
      if (hold_v) begin
        n_checks++; if (out_valid !== 1'b1 || {OVF, Cout, S} !== held) begin n_fail++; $display("FAIL rand_hold: got %b/%h want 1/%h", out_valid, {OVF, Cout, S}, held); end
      end
      if (!stuck) begin
        if (sent < NRAND && $urandom_range(3) != 0) begin
          in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
          Cin = 1'($urandom); SUB = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      take = in_valid && in_ready;
      give = out_valid && out_ready;
      if (give) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got %h want no result", {OVF, Cout, S});
        end else begin
          e = q.pop_front();
          if ({OVF, Cout, S} !== e) begin n_fail++; $display("FAIL rand_result[%0d]: got %h want %h", got, {OVF, Cout, S}, e); end
        end
        if (nprint < 8) begin $display("rand: result %0d {OVF,Cout,S}=%h", got, {OVF, Cout, S}); nprint++; end
        got++;
      end
      hold_v = out_valid && !out_ready;
      held   = {OVF, Cout, S};
      if (take) begin q.push_back(ref_model(A, B, Cin, SUB)); sent++; end
      stuck = in_valid && !take;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (got != NRAND) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got, NRAND); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d want 0", q.size()); end
    $display("rand: %0d transactions compared", got);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; SUB = 1'b0;
    test_reset();
    test_single_add();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
